// File: rtl/reg_scan_display.sv
// Button debouncer: 2-FF sync, level filter, rising-level pulse; armed only after a clean release.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES + 1 registered pulse cycle.
// No backpressure: a free-running sampler of a raw asynchronous input.
module reg_scan_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_q1;
    logic          sync_q2;
    logic          level;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] quiet_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            level     <= 1'b0;
            armed     <= 1'b0;
            cnt       <= '0;
            quiet_cnt <= '0;
            pulse     <= 1'b0;
        end else begin
            sync_q1 <= btn;
            sync_q2 <= sync_q1;
            pulse   <= 1'b0;
            if (sync_q2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_q2;
                cnt   <= '0;
                pulse <= sync_q2 & armed;
            end else begin
                cnt <= cnt + 1'b1;
            end
            // A button still held through reset must be seen released before it can step.
            if (sync_q2) begin
                quiet_cnt <= '0;
            end else if (quiet_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                armed <= 1'b1;
            end else begin
                quiet_cnt <= quiet_cnt + 1'b1;
            end
        end
    end
endmodule

// Register-inspection front end: button-stepped reg_addr, settled capture of final_res, 4-digit hex display.
// Latency: address step 1 cycle after debounced pulse; capture SETTLE_CYCLES+1 cycles after the step.
// No backpressure: final_res is assumed valid SETTLE_CYCLES after reg_addr changes.
module reg_scan_display #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SETTLE_CYCLES   = 4,
    parameter int REFRESH_BITS    = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic [15:0] final_res,
    output logic [4:0]  reg_addr,
    output logic        disp_valid,
    output logic [6:0]  seg,
    output logic [3:0]  an
);
    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [SW-1:0]           settle_cnt;
    logic [SW-1:0]           settle_cnt_nxt;
    logic                    pulse_next;
    logic                    pulse_prev;
    logic                    addr_chg;
    logic                    capture_en;
    logic [15:0]             disp_val;
    logic [REFRESH_BITS-1:0] refresh;
    logic [1:0]              digit;
    logic [3:0]              nibble;

    reg_scan_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_next),
        .pulse (pulse_next)
    );

    reg_scan_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_prev (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_prev),
        .pulse (pulse_prev)
    );

    // Simultaneous next+prev cancel out and are not an address change.
    assign addr_chg = pulse_next ^ pulse_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_addr <= '0;
        end else if (pulse_next && !pulse_prev) begin
            reg_addr <= reg_addr + 5'd1;
        end else if (pulse_prev && !pulse_next) begin
            reg_addr <= reg_addr - 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            settle_cnt <= '0;
        end else begin
            state      <= state_nxt;
            settle_cnt <= settle_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        settle_cnt_nxt = settle_cnt;
        case (state)
            IDLE: begin
                if (addr_chg) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (addr_chg) begin
                    settle_cnt_nxt = SETTLE_LOAD;
                end else if (settle_cnt == '0) begin
                    state_nxt = CAPTURE;
                end else begin
                    settle_cnt_nxt = settle_cnt - 1'b1;
                end
            end
            CAPTURE: begin
                if (addr_chg) begin
                    state_nxt      = SETTLE;
                    settle_cnt_nxt = SETTLE_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        disp_valid = (state == IDLE);
        capture_en = (state == IDLE) || (state == CAPTURE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            disp_val <= '0;
        end else if (capture_en) begin
            disp_val <= final_res;
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign digit  = refresh[REFRESH_BITS-1 -: 2];
    assign nibble = disp_val[{digit, 2'b00} +: 4];

    // an and seg share one register stage so the lit digit always matches its pattern.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh <= '0;
            an      <= 4'b1110;
            seg     <= 7'b1000000;
        end else begin
            refresh <= refresh + 1'b1;
            an      <= ~(4'b0001 << digit);
            seg     <= hex7(nibble);
        end
    end
endmodule

// File: tb/tb_reg_scan_display.sv
module tb_reg_scan_display;
    localparam int DEB = 4;
    localparam int SET = 2;
    localparam int RB  = 4;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        btn_next  = 1'b0;
    logic        btn_prev  = 1'b0;
    logic [15:0] final_res = '0;
    logic [4:0]  reg_addr;
    logic        disp_valid;
    logic [6:0]  seg;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    reg_scan_display #(
        .DEBOUNCE_CYCLES (DEB),
        .SETTLE_CYCLES   (SET),
        .REFRESH_BITS    (RB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_next   (btn_next),
        .btn_prev   (btn_prev),
        .final_res  (final_res),
        .reg_addr   (reg_addr),
        .disp_valid (disp_valid),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fval(input logic [4:0] a);
        return 16'hA5C3 ^ ({11'd0, a} * 16'h0841);
    endfunction

    function automatic logic [3:0] nib(input logic [15:0] v, input int d);
        logic [15:0] s;
        s = v >> (4 * d);
        return s[3:0];
    endfunction

    // Core model: returns the value of the register addressed one cycle earlier.
    logic        tie = 1'b0;
    logic [15:0] fr_manual = '0;
    always @(posedge clk) final_res <= tie ? fval(reg_addr) : fr_manual;

    // Monitor: display only ever shows a fully captured register; valid-low windows have a known length.
    logic       mon_en    = 1'b0;
    logic [4:0] disp_addr = '0;
    int         low_len   = 0;
    int         low_runs  = 0;
    int         exp_low   = SET + 1;
    int         mon_d;

    always @(negedge clk) begin
        if (mon_en) begin
            if (!disp_valid) begin
                low_len++;
            end else if (low_len != 0) begin
                check("valid_low_len", low_len, exp_low);
                low_runs++;
                low_len = 0;
            end
            mon_d = -1;
            for (int i = 0; i < 4; i++)
                if (an == ~(4'b0001 << i)) mon_d = i;
            check("an_onehot", (mon_d >= 0), 1);
            if (mon_d >= 0)
                check("no_interm", seg, hex_tab[nib(fval(disp_addr), mon_d)]);
            if (disp_valid) disp_addr = reg_addr;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input bit nxt, input bit prv, input int hold, input int gap);
        btn_next = nxt;
        btn_prev = prv;
        cyc(hold);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cyc(gap);
    endtask

    int         exp_addr;
    int         runs0;
    int         op;
    int         waited;
    bit         seen [4];
    logic [6:0] segs [4];

    initial begin
        // Reset state and digit multiplexing with a fixed value.
        rst = 1'b0;
        cyc(3);
        check("rst_addr", reg_addr, 0);
        check("rst_an", an, 4'b1110);
        check("rst_seg", seg, 7'b1000000);
        check("rst_valid", disp_valid, 1);
        fr_manual = 16'h1234;
        rst = 1'b1;
        cyc(4);
        for (int i = 0; i < 4; i++) seen[i] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (an == ~(4'b0001 << i)) begin
                    seen[i] = 1'b1;
                    segs[i] = seg;
                end
        end
        for (int i = 0; i < 4; i++) begin
            check("digit_seen", seen[i], 1);
            check("digit_seg", segs[i], hex_tab[nib(16'h1234, i)]);
        end

        tie = 1'b1;
        cyc(6);
        disp_addr = reg_addr;
        low_len   = 0;
        mon_en    = 1'b1;
        exp_addr  = 0;

        // Long hold steps once; short glitch is filtered.
        runs0 = low_runs;
        press(1, 0, 10, 12);
        exp_addr = (exp_addr + 1) % 32;
        check("hold_once", reg_addr, exp_addr);
        check("hold_event", low_runs - runs0, 1);
        runs0 = low_runs;
        press(1, 0, 2, 12);
        check("glitch_addr", reg_addr, exp_addr);
        check("glitch_event", low_runs - runs0, 0);

        // Wrap in both directions and aligned presses.
        press(0, 1, 10, 12);
        press(0, 1, 10, 12);
        exp_addr = 31;
        check("wrap_down", reg_addr, exp_addr);
        press(1, 0, 10, 12);
        exp_addr = 0;
        check("wrap_up", reg_addr, exp_addr);
        press(0, 1, 10, 12);
        exp_addr = 31;
        check("prev_31", reg_addr, exp_addr);
        runs0 = low_runs;
        press(1, 1, 10, 12);
        check("both_addr", reg_addr, exp_addr);
        check("both_event", low_runs - runs0, 0);

        // Randomized press sequence against the address model.
        for (int it = 0; it < 16; it++) begin
            op    = $urandom_range(0, 2);
            runs0 = low_runs;
            press(op == 0 || op == 2, op == 1 || op == 2,
                  $urandom_range(8, 12), $urandom_range(10, 14));
            if (op == 0) exp_addr = (exp_addr + 1) % 32;
            if (op == 1) exp_addr = (exp_addr + 31) % 32;
            check("rand_addr", reg_addr, exp_addr);
            check("rand_event", low_runs - runs0, (op == 2) ? 0 : 1);
        end

        // Second press during SETTLE restarts the wait.
        exp_low  = SET + 1 + 2;
        runs0    = low_runs;
        btn_next = 1'b1;
        cyc(2);
        btn_prev = 1'b1;
        cyc(10);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        cyc(14);
        check("restart_addr", reg_addr, exp_addr);
        check("restart_event", low_runs - runs0, 1);
        exp_low = SET + 1;

        // Reset while settling with the button held.
        btn_next = 1'b1;
        waited   = 0;
        while (disp_valid && waited < 20) begin
            cyc(1);
            waited++;
        end
        check("settle_seen", disp_valid, 0);
        mon_en = 1'b0;
        rst    = 1'b0;
        cyc(3);
        check("rst2_addr", reg_addr, 0);
        check("rst2_an", an, 4'b1110);
        check("rst2_seg", seg, 7'b1000000);
        check("rst2_valid", disp_valid, 1);
        rst = 1'b1;
        cyc(15);
        check("held_no_step", reg_addr, 0);
        btn_next = 1'b0;
        cyc(12);
        check("release_no_step", reg_addr, 0);
        press(1, 0, 10, 12);
        check("repress_step", reg_addr, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
